// File: rtl/uart_rx_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART RX DMA path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam logic RD_SEL_DATA   = 1'b0;
    localparam logic RD_SEL_STATUS = 1'b1;

    // STATUS register layout; firmware headers mirror these positions
    localparam int STAT_COUNT_LSB     = 0;
    localparam int STAT_COUNT_W       = 5;
    localparam int STAT_EMPTY_BIT     = 5;
    localparam int STAT_FULL_BIT      = 6;
    localparam int STAT_OVERRUN_BIT   = 7;
    localparam int STAT_FRAME_ERR_BIT = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(27_000_000, 115200);

endpackage
`default_nettype wire

// File: rtl/uart_rx_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dma_if
// Description : IO-decoder read port of the UART RX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_dma_if;

    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        rx_ready;

    modport master (output rd_en, output rd_sel, input rd_data, input rx_ready);
    modport slave  (input rd_en, input rd_sel, output rd_data, output rx_ready);

endinterface
`default_nettype wire

// File: rtl/uart_rx_dma_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 deserialiser: synchroniser, framing FSM and shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  wire        clk,
    input  wire        reset,
    input  wire        rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [1:0]         r_warm;
    rx_state_t          r_state;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_fall;

    // r_warm holds off edge detection until r_prev reflects the real line,
    // so a line already low when reset releases is not taken as a start.
    assign w_fall    = (r_warm == 2'd3) && r_prev && !r_sync2;
    assign byte_data = r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_warm     <= 2'd0;
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1    <= rx;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_clk_cnt <= '0;
                        r_bit_idx <= 3'd0;
                    end
                end
                ST_START: begin
                    if (r_clk_cnt == c_half_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == c_bit_last) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                ST_STOP: begin
                    if (r_clk_cnt == c_bit_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                        if (r_sync2) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_dma.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dma
// Description : UART receiver feeding a circular buffer drained over the IO window.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_dma
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  wire          clk,
    input  wire          reset,
    input  wire          uart_rx,
    uart_rx_dma_if.slave bus
);

    localparam int                 c_clks_per_bit = clks_per_bit(CLK_FREQ, BAUD);
    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic               w_byte_valid;
    logic [7:0]         w_byte_data;
    logic               w_frame_err_evt;

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_overrun;
    logic               r_frame_err;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_overrun_evt;
    logic               w_status_rd;
    logic [31:0]        w_status;
    logic [31:0]        w_rd_mux;

    uart_rx #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err_evt)
    );

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_depth);
    assign w_pop         = bus.rd_en && (bus.rd_sel == RD_SEL_DATA) && !w_empty;
    // A same-cycle pop frees the head slot, so a push into a full buffer still lands
    assign w_push        = w_byte_valid && (!w_full || w_pop);
    assign w_overrun_evt = w_byte_valid && w_full && !w_pop;
    assign w_status_rd   = bus.rd_en && (bus.rd_sel == RD_SEL_STATUS);
    assign bus.rx_ready  = !w_empty;

    always_comb begin
        w_status = 32'd0;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(r_count);
        w_status[STAT_EMPTY_BIT]     = w_empty;
        w_status[STAT_FULL_BIT]      = w_full;
        w_status[STAT_OVERRUN_BIT]   = r_overrun;
        w_status[STAT_FRAME_ERR_BIT] = r_frame_err;

        w_rd_mux = 32'd0;
        if (bus.rd_sel == RD_SEL_STATUS) begin
            w_rd_mux = w_status;
        end else if (!w_empty) begin
            w_rd_mux = 32'({1'b1, r_mem[r_rd_ptr]});
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            bus.rd_data <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            // New error events take priority over the clear-on-read
            r_overrun   <= w_overrun_evt   || (r_overrun   && !w_status_rd);
            r_frame_err <= w_frame_err_evt || (r_frame_err && !w_status_rd);
            if (bus.rd_en) begin
                bus.rd_data <= w_rd_mux;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_dma
// Description : Directed scoreboard bench for the UART RX DMA buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_dma;
    import uart_pkg::*;

    // 12.8 MHz / 100 kbaud gives 128 clocks per bit, keeping the run short
    localparam int CPB = 128;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic rx_line = 1'b1;
    logic rd_q    = 1'b0;
    logic hit     = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q  [$];
    string       name_q [$];

    uart_rx_dma_if bus ();

    uart_rx_dma #(
        .CLK_FREQ (12_800_000),
        .BAUD     (100_000),
        .DEPTH    (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (rx_line),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: rd_data is presented the cycle after a captured strobe
    always @(posedge clk) rd_q <= bus.rd_en;

    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: got 0x%08h, want no read output", bus.rd_data);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, bus.rd_data, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx_line = 1'b1;
        tick(4);
    endtask

    task automatic expect_rd(input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic rd(input logic sel, input logic [31:0] exp, input string name);
        expect_rd(exp, name);
        bus.rd_sel = sel;
        bus.rd_en  = 1'b1;
        tick(1);
        bus.rd_en  = 1'b0;
        tick(1);
    endtask

    task automatic drain(input int n, input logic [7:0] first, input string name);
        for (int i = 0; i < n; i++) expect_rd(32'h100 | 32'(first + 8'(i)), name);
        bus.rd_sel = RD_SEL_DATA;
        bus.rd_en  = 1'b1;
        tick(n);
        bus.rd_en  = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rd_en  = 1'b0;
        bus.rd_sel = 1'b0;
        tick(5);
        check("reset_rd_data", bus.rd_data, 32'd0);
        check("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        reset = 1'b0;
        tick(4);
        rd(RD_SEL_STATUS, 32'h20, "reset_status");

        // Single byte, status then data; rx_ready falls right after the pop
        send_byte(8'hA5, 1'b1);
        check("t1_rx_ready_high", {31'd0, bus.rx_ready}, 32'd1);
        rd(RD_SEL_STATUS, 32'h01, "t1_status");
        expect_rd(32'h1A5, "t1_data");
        bus.rd_sel = RD_SEL_DATA;
        bus.rd_en  = 1'b1;
        tick(1);
        bus.rd_en  = 1'b0;
        check("t1_rx_ready_low", {31'd0, bus.rx_ready}, 32'd0);
        tick(1);

        // Overflow: 17 bytes, the 17th is dropped
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
        rd(RD_SEL_STATUS, 32'hD0, "t2_status_overrun");
        rd(RD_SEL_STATUS, 32'h50, "t2_status_cleared");
        drain(16, 8'h00, "t2_drain");
        rd(RD_SEL_STATUS, 32'h20, "t2_status_empty");
        rd(RD_SEL_DATA, 32'h0, "t2_data_empty");

        // Short low glitch rejected at the mid-start sample
        rx_line = 1'b0;
        tick(50);
        rx_line = 1'b1;
        tick(2 * CPB);
        rd(RD_SEL_STATUS, 32'h20, "t3_glitch_status");
        rd(RD_SEL_DATA, 32'h0, "t3_glitch_data");

        // Framing error: stop bit low
        send_byte(8'h3C, 1'b0);
        tick(CPB);
        rd(RD_SEL_STATUS, 32'h120, "t4_frame_err");
        rd(RD_SEL_STATUS, 32'h20, "t4_frame_err_cleared");

        // Full buffer, pop coincides with push of 0x77
        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1);
        rd(RD_SEL_STATUS, 32'h50, "t5_prefill_status");
        hit = 1'b0;
        fork
            send_byte(8'h77, 1'b1);
            begin
                for (int c = 0; c < 3000 && !hit; c++) begin
                    tick(1);
                    if (dut.w_byte_valid) begin
                        expect_rd(32'h160, "t5_collide_pop");
                        bus.rd_sel = RD_SEL_DATA;
                        bus.rd_en  = 1'b1;
                        tick(1);
                        bus.rd_en  = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        check("t5_collision_seen", {31'd0, hit}, 32'd1);
        rd(RD_SEL_STATUS, 32'h50, "t5_status_after");
        drain(15, 8'h61, "t5_drain");
        rd(RD_SEL_DATA, 32'h177, "t5_wrap_last");
        rd(RD_SEL_STATUS, 32'h20, "t5_status_empty");

        // Reset mid-DATA with the line held low afterwards
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_line = 1'b0;
        reset   = 1'b1;
        tick(3);
        reset   = 1'b0;
        check("t6_rd_data_after_reset", bus.rd_data, 32'd0);
        tick(12 * CPB);
        check("t6_rd_data_line_low", bus.rd_data, 32'd0);
        check("t6_rx_ready_line_low", {31'd0, bus.rx_ready}, 32'd0);
        rd(RD_SEL_STATUS, 32'h20, "t6_status");
        rx_line = 1'b1;
        tick(2 * CPB);
        send_byte(8'h5A, 1'b1);
        check("t6_rx_ready_5a", {31'd0, bus.rx_ready}, 32'd1);
        rd(RD_SEL_DATA, 32'h15A, "t6_data_5a");
        rd(RD_SEL_STATUS, 32'h20, "t6_status_end");

        tick(4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
